// File: rtl/mips_fetch_stage_pkg.sv
// Purpose : shared types and constants for the MIPS-lite instruction-fetch stage.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
// Contents: address/word widths, PC increment, HALT opcode, NOP word, fetch FSM states,
//           IF/ID buffer struct and a HALT-detect helper.
package mips_fetch_stage_pkg;

   localparam int ADD_WIDTH         = 32;
   localparam int INSTRUCTION_WIDTH = 32;
   localparam int MEM_DEPTH         = 4096;

   // PC increment: bytes per instruction
   localparam logic [ADD_WIDTH-1:0]         BPI         = ADD_WIDTH'(4);
   localparam logic [5:0]                   HALT_OPCODE = 6'b010001;
   // Bubble is sll $0,$0,0, i.e. the all-zero word
   localparam logic [INSTRUCTION_WIDTH-1:0] NOP_WORD    = '0;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [ADD_WIDTH-1:0]         pc;
      logic [INSTRUCTION_WIDTH-1:0] instruct;
   } fetch_buf_t;

   function automatic logic is_halt(input logic [INSTRUCTION_WIDTH-1:0] instr);
      return instr[INSTRUCTION_WIDTH-1 -: 6] == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/mips_fetch_stage_if.sv
// Purpose : bundles the instruction-memory port and the IF/ID register outputs.
// Latency : n/a (wires only).
// Backpressure: none; stalling is a separate level input to the fetch stage.
// Signals : imem_addr (fetch byte address), imem_rdata (word at imem_addr, combinational),
//           if_valid / if_pc / if_instr (IF/ID contents). master = fetch stage, slave = memory/decode.
interface mips_fetch_stage_if;
   import mips_fetch_stage_pkg::*;

   logic [ADD_WIDTH-1:0]         imem_addr;
   logic [INSTRUCTION_WIDTH-1:0] imem_rdata;
   logic                         if_valid;
   logic [ADD_WIDTH-1:0]         if_pc;
   logic [INSTRUCTION_WIDTH-1:0] if_instr;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output if_valid,
      output if_pc,
      output if_instr
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  if_valid,
      input  if_pc,
      input  if_instr
   );

endinterface

// File: rtl/mips_fetch_stage_pc_reg.sv
// Purpose : program counter (module fetch_pc_reg) with redirect, stall and halt hold.
// Latency : new PC visible one clock after the controlling inputs.
// Backpressure: i_stall or i_hold freezes the PC; i_redirect_valid overrides both.
// Ports   : i_clk, i_rst_n (sync, active-low), i_redirect_valid, i_redirect_pc,
//           i_stall, i_hold, o_pc.
module fetch_pc_reg
   import mips_fetch_stage_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_redirect_valid,
   input  logic [ADD_WIDTH-1:0] i_redirect_pc,
   input  logic                 i_stall,
   input  logic                 i_hold,
   output logic [ADD_WIDTH-1:0] o_pc
);

   logic [ADD_WIDTH-1:0] r_pc;
   logic [ADD_WIDTH-1:0] w_redirect_aligned;

   // Redirect targets are forced word-aligned; the low two bits are simply dropped.
   assign w_redirect_aligned = i_redirect_pc & ~ADD_WIDTH'(3);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_pc <= '0;
      end else if (i_redirect_valid) begin
         r_pc <= w_redirect_aligned;
      end else if (!i_stall && !i_hold) begin
         r_pc <= r_pc + BPI;  // wraps modulo 2^ADD_WIDTH
      end
   end

   assign o_pc = r_pc;

endmodule

// File: rtl/mips_fetch_stage.sv
// Purpose : MIPS-lite IF stage: owns the PC, fetches one word per cycle, drives IF/ID.
// Latency : PC on imem_addr in cycle N, instruction on if_* after the edge ending cycle N.
// Backpressure: i_stall holds PC and IF/ID; i_redirect_valid overrides stall and HALT.
// Ports   : i_clk, i_rst_n (sync, active-low), i_stall, i_redirect_valid, i_redirect_pc,
//           bus (mips_fetch_stage_if.master), o_halted; o_fetch_count / o_stall_count
//           exist only when FETCH_STATS_EN is defined.
module mips_fetch_stage
   import mips_fetch_stage_pkg::*;
(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_stall,
   input  logic                 i_redirect_valid,
   input  logic [ADD_WIDTH-1:0] i_redirect_pc,
   mips_fetch_stage_if.master   bus,
   output logic                 o_halted
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]          o_fetch_count,
   output logic [31:0]          o_stall_count
`endif
);

   fetch_state_t         r_state;
   fetch_buf_t           r_ifid;
   logic                 r_if_valid;
   logic                 r_halted;
   logic [ADD_WIDTH-1:0] w_pc;
   logic                 w_is_halt;
   logic                 w_hold;

   assign w_is_halt = is_halt(bus.imem_rdata);
   // PC freezes once halted, and also on the edge that loads the HALT word itself.
   assign w_hold    = (r_state == ST_HALT) || w_is_halt;

   fetch_pc_reg u_pc_reg (
      .i_clk            (i_clk),
      .i_rst_n          (i_rst_n),
      .i_redirect_valid (i_redirect_valid),
      .i_redirect_pc    (i_redirect_pc),
      .i_stall          (i_stall),
      .i_hold           (w_hold),
      .o_pc             (w_pc)
   );

   // FSM, IF/ID register and halted flag share one priority chain:
   // reset > redirect > stall > normal fetch.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= ST_RUN;
         r_ifid     <= '0;
         r_if_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else if (i_redirect_valid) begin
         // Flush; a HALT fetched in the branch shadow is discarded here.
         r_state    <= ST_RUN;
         r_ifid     <= '0;
         r_if_valid <= 1'b0;
         r_halted   <= 1'b0;
      end else if (i_stall) begin
         r_state    <= r_state;
      end else if (r_state == ST_RUN) begin
         r_ifid     <= '{pc: w_pc, instruct: bus.imem_rdata};
         r_if_valid <= 1'b1;
         if (w_is_halt) begin
            r_state <= ST_HALT;
         end
      end else begin
         // Halted: keep feeding bubbles to decode.
         r_ifid     <= '{pc: '0, instruct: NOP_WORD};
         r_if_valid <= 1'b0;
         r_halted   <= 1'b1;
      end
   end

`ifdef FETCH_STATS_EN
   logic [31:0] r_fetch_count;
   logic [31:0] r_stall_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_fetch_count <= '0;
         r_stall_count <= '0;
      end else if (!i_redirect_valid) begin
         if (i_stall) begin
            r_stall_count <= r_stall_count + 32'd1;
         end else if (r_state == ST_RUN) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
      end
   end

   assign o_fetch_count = r_fetch_count;
   assign o_stall_count = r_stall_count;
`endif

   assign bus.imem_addr = w_pc;
   assign bus.if_valid  = r_if_valid;
   assign bus.if_pc     = r_ifid.pc;
   assign bus.if_instr  = r_ifid.instruct;
   assign o_halted      = r_halted;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Purpose : directed self-checking bench for mips_fetch_stage.
// Latency : checks sampled on the falling edge after each rising edge.
// Backpressure: exercises stall, redirect-over-stall, HALT and redirect-over-HALT.
module tb_mips_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halted;
`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] mem [0:1023];

   mips_fetch_stage_if bus();

   // Byte-addressed memory, indexed modulo 4096
   assign bus.imem_rdata = mem[bus.imem_addr[11:2]];

   mips_fetch_stage dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_stall          (stall),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .bus              (bus),
      .o_halted         (halted)
`ifdef FETCH_STATS_EN
      ,
      .o_fetch_count    (fetch_count),
      .o_stall_count    (stall_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic redirect_to(input logic [31:0] target);
      redirect_valid = 1'b1;
      redirect_pc    = target;
      tick();
      redirect_valid = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[0]    = 32'h20010005;
      mem[1]    = 32'h20020003;
      mem[2]    = 32'h20030001;
      mem[3]    = 32'h20040002;
      mem[4]    = 32'h44000000;   // HALT @0x10
      mem[8]    = 32'h200600FF;   // @0x20
      mem[16]   = 32'h2005000A;   // @0x40
      mem[1023] = 32'h20070007;   // @0xFFC

      rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      @(negedge clk);
      tick();
      tick();
      check_eq("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
      check_eq("rst_if_pc", bus.if_pc, 32'h0);
      check_eq("rst_if_instr", bus.if_instr, 32'h0);
      check_eq("rst_imem_addr", bus.imem_addr, 32'h0);
      check_eq("rst_halted", {31'b0, halted}, 32'h0);
`ifdef FETCH_STATS_EN
      check_eq("rst_fetch_count", fetch_count, 32'd0);
      check_eq("rst_stall_count", stall_count, 32'd0);
`endif

      // First fetches after reset release
      rst_n = 1'b1;
      tick();
      check_eq("e1_if_pc", bus.if_pc, 32'h0);
      check_eq("e1_if_instr", bus.if_instr, 32'h20010005);
      check_eq("e1_if_valid", {31'b0, bus.if_valid}, 32'h1);
      check_eq("e1_imem_addr", bus.imem_addr, 32'h4);
      tick();
      check_eq("e2_if_pc", bus.if_pc, 32'h4);
      check_eq("e2_if_instr", bus.if_instr, 32'h20020003);

      // Three stalled cycles at pc=8
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("stall_if_pc", bus.if_pc, 32'h4);
         check_eq("stall_if_instr", bus.if_instr, 32'h20020003);
         check_eq("stall_imem_addr", bus.imem_addr, 32'h8);
      end
      stall = 1'b0;
`ifdef FETCH_STATS_EN
      check_eq("stall_count_3", stall_count, 32'd3);
`endif
      tick();
      check_eq("resume_if_pc", bus.if_pc, 32'h8);
      check_eq("resume_if_instr", bus.if_instr, 32'h20030001);

      // Redirect to 0x43 while stalled: redirect wins, target aligned
      stall = 1'b1;
      redirect_to(32'h43);
      stall = 1'b0;
      check_eq("redir_if_valid", {31'b0, bus.if_valid}, 32'h0);
      check_eq("redir_imem_addr", bus.imem_addr, 32'h40);
`ifdef FETCH_STATS_EN
      check_eq("redir_stall_count", stall_count, 32'd3);
`endif
      tick();
      check_eq("redir_if_pc", bus.if_pc, 32'h40);
      check_eq("redir_if_instr", bus.if_instr, 32'h2005000A);
`ifdef FETCH_STATS_EN
      check_eq("redir_fetch_count", fetch_count, 32'd4);
`endif

      // Run into HALT at 0x10
      redirect_to(32'h0C);
      tick();                       // loads 0x0C
      tick();                       // loads HALT
      check_eq("halt_if_instr", bus.if_instr, 32'h44000000);
      check_eq("halt_if_valid", {31'b0, bus.if_valid}, 32'h1);
      check_eq("halt_imem_addr", bus.imem_addr, 32'h10);
      check_eq("halt_not_yet", {31'b0, halted}, 32'h0);
      tick();
      check_eq("halted_set", {31'b0, halted}, 32'h1);
      check_eq("halted_bubble", {31'b0, bus.if_valid}, 32'h0);
      check_eq("halted_bubble_instr", bus.if_instr, 32'h0);
      tick();
      check_eq("halted_imem_addr", bus.imem_addr, 32'h10);
`ifdef FETCH_STATS_EN
      check_eq("halted_fetch_count", fetch_count, 32'd6);
`endif

      // HALT fetched in the same cycle as a redirect to 0x20
      redirect_to(32'h10);
      check_eq("hs_clear_halted", {31'b0, halted}, 32'h0);
      redirect_to(32'h20);          // HALT is on imem_rdata during this edge
      check_eq("hs_halted", {31'b0, halted}, 32'h0);
      check_eq("hs_imem_addr", bus.imem_addr, 32'h20);
      tick();
      check_eq("hs_if_pc", bus.if_pc, 32'h20);
      check_eq("hs_if_instr", bus.if_instr, 32'h200600FF);
      check_eq("hs_halted2", {31'b0, halted}, 32'h0);
`ifdef FETCH_STATS_EN
      check_eq("hs_fetch_count", fetch_count, 32'd7);
`endif

      // PC crossing the memory size: 0xFFC -> 0x1000 reads index 0
      redirect_to(32'hFFC);
      tick();
      check_eq("wrap_if_instr", bus.if_instr, 32'h20070007);
      check_eq("wrap_imem_addr", bus.imem_addr, 32'h1000);
      tick();
      check_eq("wrap_if_pc", bus.if_pc, 32'h1000);
      check_eq("wrap_if_instr0", bus.if_instr, 32'h20010005);

      // Reset while halted
      redirect_to(32'h10);
      tick();
      tick();
      check_eq("pre_rst_halted", {31'b0, halted}, 32'h1);
      rst_n = 1'b0;
      tick();
      check_eq("mid_rst_halted", {31'b0, halted}, 32'h0);
      check_eq("mid_rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
      check_eq("mid_rst_if_instr", bus.if_instr, 32'h0);
      check_eq("mid_rst_imem_addr", bus.imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
      check_eq("mid_rst_fetch_count", fetch_count, 32'd0);
`endif
      rst_n = 1'b1;
      tick();
      check_eq("post_rst_if_pc", bus.if_pc, 32'h0);
      check_eq("post_rst_if_instr", bus.if_instr, 32'h20010005);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
